// File: rtl/surf_cin_serializer_if.sv
// Command handshake bundle between a command source and the CIN framer.
// A word transfers on every sysclk edge where cmd_valid_i and cmd_ready_o are both high;
// the source keeps cmd_data_i stable while valid is high and ready is low.
interface surf_cin_serializer_if;
  logic [31:0] cmd_data_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;

  modport master (
    output cmd_data_i,
    output cmd_valid_i,
    input  cmd_ready_o
  );

  modport slave (
    input  cmd_data_i,
    input  cmd_valid_i,
    output cmd_ready_o
  );
endinterface

// File: rtl/surf_cin_serializer.sv
// TURFIO->SURF CIN transmit framer: one 32-bit word per sync-aligned 8-cycle frame,
// shifted out MS nibble first onto a registered 4-bit phy bus.
module surf_cin_serializer #(
  parameter logic        CIN_INV       = 1'b0,
  parameter logic [31:0] IDLE_WORD     = 32'h0000_0000,
  parameter logic [31:0] TRAIN_PATTERN = 32'hA55A_6996
) (
  input  logic                         sysclk_i,
  input  logic                         rst_n_i,
  input  logic                         sync_i,
  input  logic [1:0]                   mode_i,
  surf_cin_serializer_if.slave         cmd_if,
  output logic                         cmd_sent_o,
  output logic                         locked_o,
  output logic                         sync_err_o,
  input  logic                         sync_err_clr_i,
  output logic [3:0]                   cin_o,
  output logic                         dbg_state_o
);

  localparam logic [1:0] MODE_TRAIN = 2'd1;
  localparam logic [1:0] MODE_RUN   = 2'd2;
  localparam logic [1:0] MODE_IDLE  = 2'd0;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_t;

  lock_state_t r_state;
  lock_state_t w_state_nxt;

  logic [2:0]  r_cnt;
  logic [1:0]  r_mode_q;
  logic [31:0] r_frame;
  logic        r_hold_full;
  logic [31:0] r_hold_data;
  logic        r_sent;
  logic        r_sync_err;
  logic [3:0]  r_cin;

  logic [2:0]  w_slot;
  logic        w_locked;
  logic        w_active;
  logic        w_load;
  logic        w_sync_err_set;
  logic        w_take_hold;
  logic        w_ready;
  logic        w_accept;
  logic [31:0] w_frame;
  logic [4:0]  w_bit_lo;

  // Lock FSM: leaves UNLOCKED on the first sync and only reset brings it back.
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_UNLOCKED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_UNLOCKED: if (sync_i) w_state_nxt = ST_LOCKED;
      ST_LOCKED:   w_state_nxt = ST_LOCKED;
      default:     w_state_nxt = ST_UNLOCKED;
    endcase
  end

  assign w_locked       = (r_state == ST_LOCKED);
  assign w_slot         = sync_i ? 3'd0 : r_cnt;
  // The very first sync already counts as a locked slot 0 so its frame starts immediately.
  assign w_active       = w_locked | sync_i;
  assign w_load         = w_active & (w_slot == 3'd0);
  assign w_sync_err_set = sync_i & w_locked & (r_cnt != 3'd0);
  assign w_take_hold    = w_load & (mode_i == MODE_RUN) & r_hold_full;
  assign w_ready        = w_locked & (r_mode_q == MODE_RUN) & ~r_hold_full;
  assign w_accept       = cmd_if.cmd_valid_i & w_ready;
  assign w_bit_lo       = 5'd28 - {w_slot, 2'b00};

  always_comb begin
    w_frame = r_frame;
    if (w_load) begin
      case (mode_i)
        MODE_TRAIN: w_frame = TRAIN_PATTERN;
        MODE_RUN:   w_frame = r_hold_full ? r_hold_data : IDLE_WORD;
        default:    w_frame = IDLE_WORD;
      endcase
    end
  end

  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt       <= 3'd0;
      r_mode_q    <= MODE_IDLE;
      r_frame     <= IDLE_WORD;
      r_hold_full <= 1'b0;
      r_hold_data <= 32'h0000_0000;
      r_sent      <= 1'b0;
      r_sync_err  <= 1'b0;
      r_cin       <= {4{CIN_INV}};
    end else begin
      r_cnt  <= w_slot + 3'd1;
      r_sent <= w_take_hold;

      if (w_load) begin
        r_mode_q <= mode_i;
        r_frame  <= w_frame;
      end

      // Ready is low while full, so an accept never lands on the cycle the hold drains.
      if (w_take_hold) begin
        r_hold_full <= 1'b0;
      end else if (w_accept) begin
        r_hold_full <= 1'b1;
        r_hold_data <= cmd_if.cmd_data_i;
      end

      if (w_sync_err_set) begin
        r_sync_err <= 1'b1;
      end else if (sync_err_clr_i) begin
        r_sync_err <= 1'b0;
      end

      if (w_active) begin
        r_cin <= w_frame[w_bit_lo +: 4] ^ {4{CIN_INV}};
      end else begin
        r_cin <= {4{CIN_INV}};
      end
    end
  end

  assign cmd_if.cmd_ready_o = w_ready;
  assign cmd_sent_o         = r_sent;
  assign locked_o           = w_locked;
  assign sync_err_o         = r_sync_err;
  assign cin_o              = r_cin;
  assign dbg_state_o        = r_state;

endmodule
